// File: rtl/seg_mux_display.sv
// Multiplexed common-anode seven-segment driver. Digit entries are written into
// a shadow buffer and copied to the displayed (active) buffer only at a frame
// boundary, so a frame never mixes old and new digits. Each digit slot opens
// with a dead time (anodes off) to avoid ghosting, and the anode on-window is
// shortened for PWM brightness. All pin outputs are registered.
module seg_mux_display #(
  parameter int DIGITS   = 8,
  parameter int STEP     = 10000,
  parameter int DEAD     = 16,
  parameter int BRIGHT_W = 3
) (
  input  logic                      clk_100mhz,
  input  logic                      nrst,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [$clog2(DIGITS)-1:0] wr_idx,
  input  logic [3:0]                wr_val,
  input  logic                      wr_dp,
  input  logic                      wr_en,
  input  logic                      commit,
  output logic                      commit_done,
  input  logic                      hex,
  input  logic [BRIGHT_W-1:0]       bright,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [DIGITS-1:0]         an,
  output logic [$clog2(DIGITS)-1:0] scan_idx
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(STEP);

  typedef struct packed {
    logic [3:0] val;
    logic       dp;
    logic       en;
  } entry_t;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [BRIGHT_W-1:0] bright_r_q, bright_r_d;
  logic                pending_q, pending_d;
  logic                commit_done_q, commit_done_d;
  entry_t              shadow_q [DIGITS];
  entry_t              shadow_d [DIGITS];
  entry_t              active_q [DIGITS];
  entry_t              active_d [DIGITS];
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [IW-1:0]       scan_idx_q, scan_idx_d;

  logic        wrap, last_idx, boundary;
  entry_t      cur;
  logic        blank, an_on;
  logic [31:0] prod, duty, cnt32;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0:    seg_decode = 7'b0000001;
      4'h1:    seg_decode = 7'b1001111;
      4'h2:    seg_decode = 7'b0010010;
      4'h3:    seg_decode = 7'b0000110;
      4'h4:    seg_decode = 7'b1001100;
      4'h5:    seg_decode = 7'b0100100;
      4'h6:    seg_decode = 7'b0100000;
      4'h7:    seg_decode = 7'b0001111;
      4'h8:    seg_decode = 7'b0000000;
      4'h9:    seg_decode = 7'b0000100;
      4'hA:    seg_decode = 7'b0001000;
      4'hB:    seg_decode = 7'b1100000;
      4'hC:    seg_decode = 7'b0110001;
      4'hD:    seg_decode = 7'b1000010;
      4'hE:    seg_decode = 7'b0110000;
      4'hF:    seg_decode = 7'b0111000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  assign wrap     = (cnt_q == CW'(STEP - 1));
  assign last_idx = (idx_q == IW'(DIGITS - 1));
  assign boundary = wrap && last_idx;
  // writes are refused while a commit is waiting so the committed image is frozen
  assign wr_ready = !pending_q;

  // scan timing: slot counter, digit index and per-slot brightness sample
  always_comb begin
    cnt_d      = wrap ? '0 : cnt_q + CW'(1);
    idx_d      = idx_q;
    bright_r_d = bright_r_q;
    if (wrap) begin
      idx_d      = last_idx ? '0 : idx_q + IW'(1);
      bright_r_d = bright;
    end
  end

  // shadow writes, commit handshake and frame-boundary copy to active
  always_comb begin
    shadow_d      = shadow_q;
    active_d      = active_q;
    pending_d     = pending_q;
    commit_done_d = 1'b0;
    if (wr_valid && wr_ready && (int'(wr_idx) < DIGITS)) begin
      shadow_d[wr_idx] = '{val: wr_val, dp: wr_dp, en: wr_en};
    end
    // only a commit registered before the boundary cycle is applied there
    if (boundary && pending_q) begin
      active_d      = shadow_q;
      pending_d     = 1'b0;
      commit_done_d = 1'b1;
    end else if (commit && !pending_q) begin
      pending_d = 1'b1;
    end
  end

  // decode, blanking and PWM window for the digit currently scanned
  always_comb begin
    cur        = active_q[idx_q];
    blank      = !cur.en || (!hex && (cur.val > 4'd9));
    prod       = (32'(bright_r_q) + 32'd1) * 32'(STEP >> BRIGHT_W);
    duty       = (prod > 32'(STEP)) ? 32'(STEP) : prod;
    cnt32      = 32'(cnt_q);
    an_on      = !blank && (cnt32 >= 32'(DEAD)) && (cnt32 < duty);
    seg_d      = blank ? 7'b1111111 : seg_decode(cur.val);
    dp_d       = blank ? 1'b1 : !(cur.dp && cur.en);
    an_d       = '1;
    if (an_on) begin
      an_d[idx_q] = 1'b0;
    end
    scan_idx_d = idx_q;
  end

  // state and output registers
  always_ff @(posedge clk_100mhz or negedge nrst) begin
    if (!nrst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      bright_r_q    <= '1;
      pending_q     <= 1'b0;
      commit_done_q <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      seg_q         <= 7'b1111111;
      dp_q          <= 1'b1;
      an_q          <= '1;
      scan_idx_q    <= '0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      bright_r_q    <= bright_r_d;
      pending_q     <= pending_d;
      commit_done_q <= commit_done_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      scan_idx_q    <= scan_idx_d;
    end
  end

  assign commit_done = commit_done_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign scan_idx    = scan_idx_q;

endmodule

// File: tb/tb_seg_mux_display.sv
// Directed bench for seg_mux_display with a 4-digit, 16-cycle-slot setup.
// cyc counts rising edges since reset release, so at a falling edge the DUT
// state is (cnt, idx) = (cyc%16, (cyc/16)%4) and the registered outputs show
// the state one cycle earlier.
module tb_seg_mux_display;
  localparam int DIGITS   = 4;
  localparam int STEP     = 16;
  localparam int DEAD     = 2;
  localparam int BRIGHT_W = 2;
  localparam int FRAME    = DIGITS * STEP;

  logic       clk_100mhz = 1'b0;
  logic       nrst       = 1'b0;
  logic       wr_valid   = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_idx     = 2'd0;
  logic [3:0] wr_val     = 4'd0;
  logic       wr_dp      = 1'b0;
  logic       wr_en      = 1'b0;
  logic       commit     = 1'b0;
  logic       commit_done;
  logic       hex        = 1'b1;
  logic [1:0] bright     = 2'd3;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic [1:0] scan_idx;

  int checks = 0;
  int errors = 0;
  int cyc;

  seg_mux_display #(
    .DIGITS(DIGITS), .STEP(STEP), .DEAD(DEAD), .BRIGHT_W(BRIGHT_W)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .nrst       (nrst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_idx     (wr_idx),
    .wr_val     (wr_val),
    .wr_dp      (wr_dp),
    .wr_en      (wr_en),
    .commit     (commit),
    .commit_done(commit_done),
    .hex        (hex),
    .bright     (bright),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .scan_idx   (scan_idx)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  always @(posedge clk_100mhz or negedge nrst) begin
    if (!nrst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk_100mhz);
  endtask

  task automatic wait_pos(input int target);
    int n;
    n = 0;
    while (((cyc % FRAME) != target) && (n < 200)) begin
      next_cyc();
      n++;
    end
    check_eq("wait_pos", 32'(cyc % FRAME), 32'(target));
  endtask

  task automatic do_write(input logic [1:0] i, input logic [3:0] v, input logic d, input logic e);
    wr_valid = 1'b1; wr_idx = i; wr_val = v; wr_dp = d; wr_en = e;
    next_cyc();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    next_cyc();
    commit = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!commit_done && (n < 150)) begin
      next_cyc();
      n++;
    end
    check_eq({tag, "_seen"}, 32'(commit_done), 32'd1);
    check_eq({tag, "_at_boundary"}, 32'(cyc % FRAME), 32'd0);
  endtask

  // watch one 16-cycle slot of digit k; lo_cnt is the hand-computed number of
  // anode-low cycles, starting right after the dead time
  task automatic check_slot(input int k, input logic [6:0] seg_e, input logic dp_e, input int lo_cnt);
    int lows;
    logic [3:0] exp_an;
    lows = 0;
    wait_pos(16 * k + 1);
    for (int c = 0; c < STEP; c++) begin
      exp_an = ((c >= DEAD) && (c < DEAD + lo_cnt)) ? ~(4'b0001 << k) : 4'hF;
      check_eq($sformatf("an_d%0d_c%0d", k, c), 32'(an), 32'(exp_an));
      check_eq($sformatf("seg_d%0d", k), 32'(seg), 32'(seg_e));
      check_eq($sformatf("dp_d%0d", k), 32'(dp), 32'(dp_e));
      check_eq($sformatf("scan_idx_d%0d", k), 32'(scan_idx), 32'(k));
      if (an != 4'hF) lows++;
      if (c < STEP - 1) next_cyc();
    end
    check_eq($sformatf("lowcount_d%0d", k), 32'(lows), 32'(lo_cnt));
  endtask

  initial begin
    int pulses;
    // 1: reset and one blank frame
    repeat (3) next_cyc();
    check_eq("rst_an", 32'(an), 32'hF);
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
    nrst = 1'b1;
    for (int i = 0; i <= FRAME; i++) begin
      check_eq("blank_an", 32'(an), 32'hF);
      check_eq("blank_seg", 32'(seg), 32'h7F);
      check_eq("blank_dp", 32'(dp), 32'd1);
      check_eq("blank_wr_ready", 32'(wr_ready), 32'd1);
      check_eq("blank_commit_done", 32'(commit_done), 32'd0);
      check_eq("blank_scan_idx", 32'(scan_idx), (i == 0) ? 32'd0 : 32'(((i - 1) / 16) % 4));
      if (i < FRAME) next_cyc();
    end

    // 2: fill four digits, commit mid-frame
    wait_pos(4);
    do_write(2'd0, 4'd1, 1'b0, 1'b1);
    do_write(2'd1, 4'd2, 1'b0, 1'b1);
    do_write(2'd2, 4'd3, 1'b1, 1'b1);
    do_write(2'd3, 4'd4, 1'b0, 1'b1);
    wait_pos(20);
    check_eq("ready_before_commit", 32'(wr_ready), 32'd1);
    pulse_commit();
    check_eq("ready_after_commit", 32'(wr_ready), 32'd0);
    wait_pos(63);
    check_eq("ready_at_boundary", 32'(wr_ready), 32'd0);
    check_eq("done_before_boundary", 32'(commit_done), 32'd0);
    next_cyc();
    check_eq("done_pulse", 32'(commit_done), 32'd1);
    check_eq("ready_after_copy", 32'(wr_ready), 32'd1);
    next_cyc();
    check_eq("done_one_cycle", 32'(commit_done), 32'd0);
    check_slot(0, 7'b1001111, 1'b1, 14);
    check_slot(1, 7'b0010010, 1'b1, 14);
    check_slot(2, 7'b0000110, 1'b0, 14);
    check_slot(3, 7'b1001100, 1'b1, 14);

    // 3: brightness changes apply from the next slot
    bright = 2'd0;
    check_slot(0, 7'b1001111, 1'b1, 14);
    check_slot(1, 7'b0010010, 1'b1, 2);
    check_slot(2, 7'b0000110, 1'b0, 2);
    check_slot(3, 7'b1001100, 1'b1, 2);
    bright = 2'd3;
    check_slot(0, 7'b1001111, 1'b1, 2);
    check_slot(1, 7'b0010010, 1'b1, 14);

    // 4: 0xB on digit 1, written in the same cycle as the commit
    wait_pos(40);
    wr_valid = 1'b1; wr_idx = 2'd1; wr_val = 4'hB; wr_dp = 1'b0; wr_en = 1'b1;
    commit = 1'b1;
    next_cyc();
    wr_valid = 1'b0; commit = 1'b0;
    wait_done("done_hexb");
    check_slot(1, 7'b1100000, 1'b1, 14);
    hex = 1'b0;
    check_slot(1, 7'b1111111, 1'b1, 0);

    // 5a: commit on the boundary cycle waits a full frame
    wait_pos(40);
    do_write(2'd3, 4'd5, 1'b0, 1'b1);
    wait_pos(63);
    pulse_commit();
    check_eq("bnd_commit_no_done", 32'(commit_done), 32'd0);
    check_eq("bnd_commit_pending", 32'(wr_ready), 32'd0);
    check_slot(3, 7'b1001100, 1'b1, 14);
    check_eq("bnd_commit_done_next", 32'(commit_done), 32'd1);
    check_slot(3, 7'b0100100, 1'b1, 14);

    // 5b/5c: write while not ready is dropped, second commit ignored
    wait_pos(5);
    pulse_commit();
    wait_pos(10);
    check_eq("ready_low_pending", 32'(wr_ready), 32'd0);
    do_write(2'd0, 4'd7, 1'b0, 1'b1);
    wait_pos(30);
    pulse_commit();
    wait_done("done_single");
    check_slot(0, 7'b1001111, 1'b1, 14);
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      next_cyc();
      if (commit_done) pulses++;
    end
    check_eq("no_second_done", 32'(pulses), 32'd0);
    check_eq("ready_after_single", 32'(wr_ready), 32'd1);

    // 6: reset while a commit is pending
    wait_pos(2);
    do_write(2'd0, 4'd8, 1'b0, 1'b1);
    pulse_commit();
    wait_pos(8);
    check_eq("pre_rst_an", 32'(an), 32'hE);
    check_eq("pre_rst_ready", 32'(wr_ready), 32'd0);
    nrst = 1'b0;
    #1;
    check_eq("rst_mid_an", 32'(an), 32'hF);
    check_eq("rst_mid_seg", 32'(seg), 32'h7F);
    check_eq("rst_mid_dp", 32'(dp), 32'd1);
    check_eq("rst_mid_scan_idx", 32'(scan_idx), 32'd0);
    check_eq("rst_mid_ready", 32'(wr_ready), 32'd1);
    check_eq("rst_mid_done", 32'(commit_done), 32'd0);
    next_cyc();
    nrst = 1'b1;
    for (int i = 0; i < 140; i++) begin
      next_cyc();
      check_eq("post_rst_an", 32'(an), 32'hF);
      check_eq("post_rst_seg", 32'(seg), 32'h7F);
      check_eq("post_rst_done", 32'(commit_done), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_mux_display.md
# seg_mux_display

Parametrised multiplexed seven-segment display driver with a double-buffered digit store, hex/decimal decode, per-digit blanking, anti-ghosting dead time and PWM brightness. Sits between the application logic and the board's common-anode display pins. Clients write digit entries into a shadow buffer through a valid/ready port, then request a commit. The commit is applied only at a frame boundary, so a displayed frame never shows a mix of old and new digits.

## Interface
- DIGITS, 8, number of multiplexed digits (2..8)
- STEP, 10000, clock cycles each digit is scanned
- DEAD, 16, cycles at the start of each digit slot with the anode forced off (DEAD < STEP>>BRIGHT_W)
- BRIGHT_W, 3, brightness input width

Ports:
- clk_100mhz  in  1  system clock
- nrst  in  1  reset; nrst, asynchronous, active-low; clock clk_100mhz
- wr_valid  in  1  shadow-buffer write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_idx  in  $clog2(DIGITS)  digit index, 0 = rightmost (an[0])
- wr_val  in  4  digit value
- wr_dp  in  1  decimal point on
- wr_en  in  1  digit enabled; 0 = blank
- commit  in  1  single-cycle pulse: copy shadow to active at next frame boundary
- commit_done  out  1  one-cycle pulse when the copy has happened
- hex  in  1  1 = decode 0-F; 0 = decode 0-9, values 10-15 blank
- bright  in  BRIGHT_W  brightness level, 0 = dimmest, all-ones = full
- seg  out  7  {ca,cb,cc,cd,ce,cf,cg}, active-low
- dp  out  1  decimal point, active-low
- an  out  DIGITS  anodes, active-low, one-hot-low or all-high
- scan_idx  out  $clog2(DIGITS)  digit currently scanned

## Operation
- Scan counter cnt runs 0..STEP-1, then wraps to 0. On each wrap, idx advances. idx wraps from DIGITS-1 to 0.
- Frame boundary: the cycle where cnt==STEP-1 and idx==DIGITS-1.
- Shadow writes: an accepted write stores {wr_val, wr_dp, wr_en} into shadow[wr_idx]. wr_idx >= DIGITS is accepted and dropped.
- wr_ready = !pending.
- commit when pending=0 sets pending. commit while pending=1 is ignored.
- A write and a commit in the same cycle: the write is accepted and is included in the commit.
- At a frame boundary with pending already 1 (registered before that cycle):
  - active <= shadow;
  - pending <= 0;
  - commit_done pulses in the next cycle.
- A commit arriving on the boundary cycle itself waits for the following boundary.
- bright is sampled into bright_r when cnt wraps (every digit slot).
- Duty: duty = (bright_r+1) * (STEP >> BRIGHT_W). Use a 32-bit product; duty saturates to STEP.
- Anode for idx is driven low iff all three hold:
  - DEAD <= cnt < duty;
  - active[idx].en = 1;
  - the decoded value is not blank.
- Otherwise all anodes are high.
- Decode patterns (ca..cg, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - blank = 1111111
- dp = !(active[idx].dp && active[idx].en).
- A blank digit forces seg=1111111 and dp=1.

## Timing
- seg, dp, an and scan_idx are registered. They reflect the cnt/idx/active state of the previous cycle (1-cycle latency).
- Anode low window for digit k is cycles [k*STEP+DEAD+1, k*STEP+duty] from frame start, inclusive.
- Full frame = DIGITS*STEP cycles. Frame time is independent of brightness.
- A commit issued at cycle t becomes visible:
  - at the latest DIGITS*STEP+2 cycles later;
  - at the earliest 2 cycles after the next boundary.
- commit_done fires exactly 1 cycle after the copying boundary.
- Reset values:
  - cnt, idx = 0; pending = 0; bright_r = all-ones;
  - all shadow and active entries en=0, val=0, dp=0;
  - seg = 1111111, dp = 1, an = all-ones, scan_idx = 0;
  - wr_ready = 1, commit_done = 0.
- Reset mid-frame aborts any pending commit. Shadow contents are lost.

## Test plan
Bench parameters: DIGITS=4, STEP=16, DEAD=2, BRIGHT_W=2.

1. Reset release -> an=1111, seg=1111111, dp=1 for a full frame (64 cycles). wr_ready=1. scan_idx cycles 0,1,2,3 every 16 cycles.
2. Write idx0..3 with val 1,2,3,4, en=1, dp on idx2 only; then commit mid-frame.
   - wr_ready low until the boundary; commit_done pulses 1 cycle after it.
   - Next frame: an[0] low for cnt 2..15 with seg=1001111; idx1=0010010; idx2 dp=0; idx3=1001100.
3. bright=0 -> each anode low for exactly 2 cycles per slot (cnt 2..3). bright=3 -> 14 cycles. The change takes effect from the next slot.
4. val=0xB on idx1:
   - hex=1 -> seg=1100000;
   - hex=0 -> an[1] stays high, seg=1111111.
5. Boundary and ignored-request cases:
   - commit asserted exactly on the boundary cycle -> no copy there; copy at the next boundary.
   - A second commit while pending -> ignored, single commit_done.
   - A write with wr_ready=0 -> not stored.
6. nrst asserted while pending=1 in mid-frame -> all outputs return to reset values immediately. No commit_done afterwards. The display stays blank.
